// File: rtl/inta_ack_sequencer_if.sv
// Handshake and bus signals between the PIC control side (resolver, command
// decoder, CPU INTA line) and the acknowledge sequencer.
interface inta_ack_sequencer_if;
    logic [7:0] chosen_interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] data_out;
    logic       data_oe;

    // Driver side: resolver, ICW/OCW registers and the CPU.
    modport master (
        output chosen_interrupt, inta_n, vector_base, aeoi, eoi, eoi_specific, eoi_level,
        input  int_out, isr, irr_clear, data_out, data_oe
    );

    // Sequencer side.
    modport slave (
        input  chosen_interrupt, inta_n, vector_base, aeoi, eoi, eoi_specific, eoi_level,
        output int_out, isr, irr_clear, data_out, data_oe
    );
endinterface

// File: rtl/inta_ack_sequencer.sv
// Responder half of the PIC INTA handshake: raises int_out, walks the
// two-pulse acknowledge, owns the In-Service Register and drives the vector.
module inta_ack_sequencer (
    input logic                 clk,
    input logic                 reset,
    inta_ack_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StPend,
        StAck1,
        StGap,
        StAck2
    } state_e;

    state_e     state_q;
    logic       inta_d_q;
    logic       spurious_q;
    logic       int_out_q;
    logic       data_oe_q;
    logic [2:0] level_q;
    logic [7:0] isr_q;
    logic [7:0] irr_clear_q;
    logic [7:0] data_out_q;

    logic       fall;
    logic       rise;
    logic [2:0] req_idx;
    logic [2:0] isr_idx;
    logic       req_qual;
    logic [7:0] req_onehot;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;
    logic [7:0] isr_d;

    // Index of the lowest set bit (IR0 is highest priority); 0 when empty.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    // INTA edge detection and request qualification against the ISR.
    always_comb begin
        fall       = inta_d_q & ~bus.inta_n;
        rise       = ~inta_d_q & bus.inta_n;
        req_idx    = lowest_idx(bus.chosen_interrupt);
        isr_idx    = lowest_idx(isr_q);
        req_onehot = 8'd1 << req_idx;
        req_qual   = (bus.chosen_interrupt != 8'd0) && ((isr_q == 8'd0) || (req_idx < isr_idx));
    end

    // ISR set/clear merge; a set applied to the same bit overrides a clear.
    always_comb begin
        isr_set = 8'd0;
        isr_clr = 8'd0;
        if ((state_q == StPend) && fall && req_qual) begin
            isr_set = req_onehot;
        end
        if ((state_q == StAck2) && rise && bus.aeoi && !spurious_q) begin
            isr_clr = isr_clr | (8'd1 << level_q);
        end
        if (bus.eoi) begin
            if (bus.eoi_specific) begin
                isr_clr = isr_clr | (8'd1 << bus.eoi_level);
            end else begin
                // Isolate the lowest set bit; zero when the ISR is empty.
                isr_clr = isr_clr | (isr_q & (~isr_q + 8'd1));
            end
        end
        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    // Acknowledge FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            inta_d_q    <= 1'b1;
            spurious_q  <= 1'b0;
            int_out_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            level_q     <= 3'd0;
            isr_q       <= 8'd0;
            irr_clear_q <= 8'd0;
            data_out_q  <= 8'd0;
        end else begin
            inta_d_q    <= bus.inta_n;
            isr_q       <= isr_d;
            irr_clear_q <= 8'd0;
            unique case (state_q)
                StIdle: begin
                    int_out_q <= 1'b0;
                    if (req_qual) begin
                        level_q <= req_idx;
                        state_q <= StPend;
                    end
                end
                StPend: begin
                    if (fall) begin
                        int_out_q <= 1'b0;
                        state_q   <= StAck1;
                        if (req_qual) begin
                            level_q     <= req_idx;
                            irr_clear_q <= req_onehot;
                            spurious_q  <= 1'b0;
                        end else begin
                            // Request withdrawn before the first pulse.
                            level_q    <= 3'd7;
                            spurious_q <= 1'b1;
                        end
                    end else begin
                        int_out_q <= 1'b1;
                        if (req_qual) level_q <= req_idx;
                    end
                end
                StAck1: begin
                    if (rise) state_q <= StGap;
                end
                StGap: begin
                    if (fall) begin
                        data_oe_q  <= 1'b1;
                        data_out_q <= {bus.vector_base, level_q};
                        state_q    <= StAck2;
                    end
                end
                StAck2: begin
                    if (rise) begin
                        data_oe_q  <= 1'b0;
                        data_out_q <= 8'd0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.int_out   = int_out_q;
    assign bus.isr       = isr_q;
    assign bus.irr_clear = irr_clear_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;

endmodule

// File: tb/tb_inta_ack_sequencer.sv
// Randomised bench for inta_ack_sequencer against a transaction-level model
// of the ISR and the vector that each acknowledge should produce.
module tb_inta_ack_sequencer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [7:0] m_isr;

    inta_ack_sequencer_if bus ();

    inta_ack_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lo_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_isr = 8'd0;
        check_eq("rst_int_out", 32'(bus.int_out), 0);
        check_eq("rst_isr", 32'(bus.isr), 0);
        check_eq("rst_irr_clear", 32'(bus.irr_clear), 0);
        check_eq("rst_data_out", 32'(bus.data_out), 0);
        check_eq("rst_data_oe", 32'(bus.data_oe), 0);
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lvl);
        int k;
        bus.eoi          = 1'b1;
        bus.eoi_specific = spec;
        bus.eoi_level    = lvl;
        if (spec) begin
            m_isr[lvl] = 1'b0;
        end else begin
            k = lo_idx(m_isr);
            if (k < 8) m_isr[k] = 1'b0;
        end
        tick();
        bus.eoi = 1'b0;
        check_eq("eoi_isr", 32'(bus.isr), 32'(m_isr));
    endtask

    // One full acknowledge attempt; wd withdraws the request before the first pulse.
    task automatic do_ack(input logic [7:0] ch, input logic [4:0] vb, input logic ae,
                          input logic wd);
        logic       qual;
        logic [2:0] lvl;
        logic [7:0] bit_m;
        int         extra_low;
        int         gap_high;
        qual = (ch != 8'd0) && (lo_idx(ch) < lo_idx(m_isr));
        bus.chosen_interrupt = ch;
        bus.vector_base      = vb;
        bus.aeoi             = ae;
        if (!qual) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("noqual_int_out", 32'(bus.int_out), 0);
            end
            bus.chosen_interrupt = 8'd0;
            tick();
            return;
        end
        tick();
        check_eq("pend_int_out_early", 32'(bus.int_out), 0);
        tick();
        check_eq("pend_int_out", 32'(bus.int_out), 1);
        if (wd) begin
            bus.chosen_interrupt = 8'd0;
            tick();
            check_eq("wd_int_out", 32'(bus.int_out), 1);
            lvl   = 3'd7;
            bit_m = 8'd0;
        end else begin
            lvl   = 3'(lo_idx(ch));
            bit_m = 8'd1 << lvl;
        end
        m_isr = m_isr | bit_m;
        // First INTA pulse.
        bus.inta_n = 1'b0;
        tick();
        bus.chosen_interrupt = 8'd0;
        check_eq("ack1_int_out", 32'(bus.int_out), 0);
        check_eq("ack1_isr", 32'(bus.isr), 32'(m_isr));
        check_eq("ack1_irr_clear", 32'(bus.irr_clear), 32'(bit_m));
        extra_low = $urandom_range(1, 2);
        for (int i = 0; i < extra_low; i++) begin
            tick();
            check_eq("ack1_irr_clear_end", 32'(bus.irr_clear), 0);
        end
        bus.inta_n = 1'b1;
        tick();
        gap_high = $urandom_range(0, 2);
        for (int i = 0; i < gap_high; i++) tick();
        check_eq("gap_data_oe", 32'(bus.data_oe), 0);
        // Second INTA pulse drives the vector.
        bus.inta_n = 1'b0;
        tick();
        check_eq("ack2_data_oe", 32'(bus.data_oe), 1);
        check_eq("ack2_data_out", 32'(bus.data_out), 32'({vb, lvl}));
        bus.vector_base = 5'($urandom);
        tick();
        check_eq("ack2_data_hold", 32'(bus.data_out), 32'({vb, lvl}));
        bus.inta_n = 1'b1;
        if (ae && !wd) m_isr = m_isr & ~bit_m;
        tick();
        check_eq("end_data_oe", 32'(bus.data_oe), 0);
        check_eq("end_isr", 32'(bus.isr), 32'(m_isr));
        tick();
        check_eq("idle_int_out", 32'(bus.int_out), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_isr = 8'd0;
        reset = 1'b1;
        bus.chosen_interrupt = 8'd0;
        bus.inta_n           = 1'b1;
        bus.vector_base      = 5'd0;
        bus.aeoi             = 1'b0;
        bus.eoi              = 1'b0;
        bus.eoi_specific     = 1'b0;
        bus.eoi_level        = 3'd0;
        #2;
        do_reset();

        // Directed cases.
        do_ack(8'h08, 5'h10, 1'b0, 1'b0);
        check_eq("dir_isr_08", 32'(bus.isr), 32'h08);
        do_eoi(1'b1, 3'd3);
        do_ack(8'h08, 5'h10, 1'b1, 1'b0);
        check_eq("dir_aeoi_isr", 32'(bus.isr), 32'h00);
        do_ack(8'h08, 5'h10, 1'b0, 1'b0);
        do_ack(8'h20, 5'h10, 1'b0, 1'b0);
        do_ack(8'h02, 5'h10, 1'b0, 1'b0);
        check_eq("dir_nested_isr", 32'(bus.isr), 32'h0A);
        do_ack(8'h01, 5'h15, 1'b1, 1'b1);
        check_eq("dir_spurious_isr", 32'(bus.isr), 32'h0A);
        do_eoi(1'b0, 3'd0);
        check_eq("dir_nseoi", 32'(bus.isr), 32'h08);
        do_eoi(1'b1, 3'd3);
        do_eoi(1'b0, 3'd0);
        check_eq("dir_eoi_empty", 32'(bus.isr), 32'h00);

        // Reset while waiting in the gap between pulses.
        bus.chosen_interrupt = 8'h04;
        tick();
        tick();
        bus.inta_n = 1'b0;
        tick();
        bus.chosen_interrupt = 8'h00;
        bus.inta_n = 1'b1;
        tick();
        do_reset();
        bus.inta_n = 1'b0;
        tick();
        check_eq("rstgap_data_oe", 32'(bus.data_oe), 0);
        check_eq("rstgap_isr", 32'(bus.isr), 0);
        bus.inta_n = 1'b1;
        tick();
        check_eq("rstgap_data_oe2", 32'(bus.data_oe), 0);
        check_eq("rstgap_int_out", 32'(bus.int_out), 0);

        // Randomised mix of acknowledges and EOIs.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_eoi(1'($urandom), 3'($urandom));
            end else begin
                do_ack(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom), 5'($urandom),
                       1'($urandom), ($urandom_range(0, 4) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
